// File: rtl/imem_ctrl_pkg.sv
// imem_ctrl_pkg: state encoding and default address width shared by the instruction-memory controller.
package imem_ctrl_pkg;

   localparam int PC_WIDTH = 10;

   typedef enum logic {
      IMEM_S_LOAD = 1'b0,
      IMEM_S_RUN  = 1'b1
   } imem_state_e;

endpackage

// File: rtl/imem_rsp_reg.sv
// imem_rsp_reg: registers the combinational inst_mem read data so fetch sees a fixed one-cycle latency.
module imem_rsp_reg
   import imem_ctrl_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clka,
   input  logic          rst_n,
   input  logic          i_gnt,
   input  logic          i_flush,
   input  logic [DW-1:0] i_rdata,
   output logic          o_rvalid,
   output logic [DW-1:0] o_rdata
);

   logic          r_rv;
   logic [DW-1:0] r_rdata;

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         r_rv    <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_rv <= i_gnt;
         if (i_gnt) begin
            r_rdata <= i_rdata;
         end
      end
   end

   // The squash is combinational so a redirect in the response cycle hides stale data at once.
   assign o_rvalid = r_rv & ~i_flush;
   assign o_rdata  = r_rdata;

endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: shares the inst_mem port between fetch reads and loader writes and sequences boot.
// Loader support is built only with IMEM_LOADER_EN; without it the core runs straight out of reset.
module imem_ctrl
   import imem_ctrl_pkg::*;
#(
   parameter int AW = PC_WIDTH,
   parameter int DW = 32
) (
   input  logic          clka,
   input  logic          rst_n,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   input  logic          f_flush,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [DW-1:0] f_rdata,
   input  logic          l_req,
   input  logic [AW-1:0] l_addr,
   input  logic [DW-1:0] l_wdata,
   input  logic          l_last,
   output logic          l_gnt,
   output logic          mem_re,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          boot_done,
   output logic [AW:0]   load_cnt
);

   logic w_f_gnt;

`ifdef IMEM_LOADER_EN
   localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

   imem_state_e   r_state;
   imem_state_e   w_state_next;
   logic          r_boot_done;
   logic          w_boot_done_next;
   logic [AW:0]   r_load_cnt;
   logic [AW:0]   w_load_cnt_next;
   logic          w_l_gnt;
   logic          w_mem_re;
   logic          w_mem_we;
   logic [AW-1:0] w_mem_addr;

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IMEM_S_LOAD;
         r_boot_done <= 1'b0;
         r_load_cnt  <= '0;
      end else begin
         r_state     <= w_state_next;
         r_boot_done <= w_boot_done_next;
         r_load_cnt  <= w_load_cnt_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_boot_done_next = r_boot_done;
      w_load_cnt_next  = r_load_cnt;
      w_l_gnt          = 1'b0;
      w_f_gnt          = 1'b0;
      w_mem_re         = 1'b0;
      w_mem_we         = 1'b0;
      w_mem_addr       = f_addr;
      case (r_state)
         IMEM_S_LOAD: begin
            w_l_gnt    = l_req;
            w_mem_we   = l_req;
            w_mem_addr = l_addr;
            if (l_req) begin
               if (r_load_cnt != CNT_MAX) begin
                  w_load_cnt_next = r_load_cnt + (AW+1)'(1);
               end
               if (l_last) begin
                  w_state_next     = IMEM_S_RUN;
                  w_boot_done_next = 1'b1;
               end
            end
         end
         IMEM_S_RUN: begin
            // A loader word while running halts fetch and opens a fresh session; that word is not
            // written here, so the loader must present it again.
            if (l_req) begin
               w_state_next     = IMEM_S_LOAD;
               w_boot_done_next = 1'b0;
               w_load_cnt_next  = '0;
            end else begin
               w_f_gnt  = f_req;
               w_mem_re = f_req;
            end
         end
         default: begin
            w_state_next = IMEM_S_LOAD;
         end
      endcase
   end

   assign l_gnt     = w_l_gnt;
   assign mem_re    = w_mem_re;
   assign mem_we    = w_mem_we;
   assign mem_addr  = w_mem_addr;
   assign mem_wdata = l_wdata;
   assign boot_done = r_boot_done;
   assign load_cnt  = r_load_cnt;
`else
   logic w_unused_loader;

   assign w_unused_loader = ^{l_req, l_addr, l_wdata, l_last};
   assign w_f_gnt         = f_req;
   assign l_gnt           = 1'b0;
   assign mem_re          = f_req;
   assign mem_we          = 1'b0;
   assign mem_addr        = f_addr;
   assign mem_wdata       = '0;
   assign boot_done       = 1'b1;
   assign load_cnt        = '0;
`endif

   assign f_gnt = w_f_gnt;

   imem_rsp_reg #(
      .DW(DW)
   ) u_rsp (
      .clka    (clka),
      .rst_n   (rst_n),
      .i_gnt   (w_f_gnt),
      .i_flush (f_flush),
      .i_rdata (mem_rdata),
      .o_rvalid(f_rvalid),
      .o_rdata (f_rdata)
   );

endmodule
